// File: rtl/spi_slave.sv
// SPI slave endpoint: synchronised Sclk/SS/MOSI, all four CPOL/CPHA modes, single-entry TX buffer.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float MISO whenever the slave is not selected.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] MODE,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    input  logic       Sclk,
    input  logic       MOSI,
    input  logic       SS,
    output logic       MISO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] ss_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic                   sclk_d_reg;
    logic                   ss_d_reg;

    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall, ss_fall;
    logic       lead_edge, trail_edge;
    logic       cpol, cpha;

    logic [1:0] mode_reg;
    logic [7:0] tx_buf_reg;
    logic       tx_full_reg;
    logic [7:0] tx_shreg_reg;
    logic [6:0] rx_shreg_reg;
    logic [7:0] rx_data_reg;
    logic       rx_valid_reg;
    logic       miso_reg;
    logic [3:0] bitcnt_reg;

    logic [7:0] load_byte;
    logic       load_first, reload, tx_shift, rx_sample, byte_load;

    // SS synchroniser resets to the deselected level so reset release cannot fake a frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_reg <= '0;
            ss_sync_reg   <= '1;
            mosi_sync_reg <= '0;
            sclk_d_reg    <= 1'b0;
            ss_d_reg      <= 1'b1;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], Sclk};
            ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], SS};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], MOSI};
            sclk_d_reg    <= sclk_s;
            ss_d_reg      <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
    assign ss_s      = ss_sync_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d_reg;
    assign sclk_fall = ~sclk_s & sclk_d_reg;
    assign ss_fall   = ss_d_reg & ~ss_s;

    assign cpol       = mode_reg[1];
    assign cpha       = mode_reg[0];
    assign lead_edge  = cpol ? sclk_fall : sclk_rise;
    assign trail_edge = cpol ? sclk_rise : sclk_fall;

    assign load_byte = tx_full_reg ? tx_buf_reg : 8'h00;
    assign byte_load = load_first | reload;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sampling edge is leading for CPHA=0 and trailing for CPHA=1; the other edge moves MISO.
    always_comb begin
        state_next = state_reg;
        load_first = 1'b0;
        reload     = 1'b0;
        tx_shift   = 1'b0;
        rx_sample  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_first = 1'b1;
                state_next = XFER;
            end
            XFER: begin
                if (lead_edge) begin
                    if (!cpha) begin
                        rx_sample = 1'b1;
                    end else if (bitcnt_reg == 4'd8) begin
                        reload = 1'b1;
                    end else begin
                        tx_shift = 1'b1;
                    end
                end
                if (trail_edge) begin
                    if (cpha) begin
                        rx_sample = 1'b1;
                    end else if (bitcnt_reg == 4'd8) begin
                        reload = 1'b1;
                    end else begin
                        tx_shift = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (ss_s) begin
            state_next = IDLE;
            load_first = 1'b0;
            reload     = 1'b0;
            tx_shift   = 1'b0;
            rx_sample  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_reg <= 2'd0;
        end else if (ss_fall) begin
            mode_reg <= MODE;
        end
    end

    // A store while empty wins over a same-cycle consume; the consume then took 8'h00.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf_reg  <= 8'h00;
            tx_full_reg <= 1'b0;
        end else if (tx_load && !tx_full_reg) begin
            tx_buf_reg  <= tx_data;
            tx_full_reg <= 1'b1;
        end else if (byte_load) begin
            tx_full_reg <= 1'b0;
        end
    end

    // CPHA=1 reload happens on a leading edge, so the MSB goes out and the byte shifts at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shreg_reg <= 8'h00;
            miso_reg     <= 1'b0;
        end else if (byte_load) begin
            miso_reg <= load_byte[7];
            if (reload && cpha) begin
                tx_shreg_reg <= {load_byte[6:0], 1'b0};
            end else begin
                tx_shreg_reg <= load_byte;
            end
        end else if (tx_shift) begin
            miso_reg     <= cpha ? tx_shreg_reg[7] : tx_shreg_reg[6];
            tx_shreg_reg <= {tx_shreg_reg[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitcnt_reg   <= 4'd0;
            rx_shreg_reg <= 7'd0;
            rx_data_reg  <= 8'h00;
            rx_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (byte_load) begin
                bitcnt_reg <= 4'd0;
                if (load_first) begin
                    rx_shreg_reg <= 7'd0;
                end
            end else if (rx_sample) begin
                bitcnt_reg   <= bitcnt_reg + 4'd1;
                rx_shreg_reg <= {rx_shreg_reg[5:0], mosi_s};
                if (bitcnt_reg == 4'd7) begin
                    rx_data_reg  <= {rx_shreg_reg, mosi_s};
                    rx_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign tx_ready = ~tx_full_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign busy     = (state_reg != IDLE);

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = busy ? miso_reg : 1'bz;
`else
    assign MISO = busy & miso_reg;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table of single-byte frames, hand-written corner sequences, and
// randomized multi-byte frames checked against a buffer-queue model of the slave.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] MODE = 2'd0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       Sclk = 1'b0;
    logic       MOSI = 1'b0;
    logic       SS = 1'b1;
    logic       MISO;

    always #5 clk = ~clk;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .MODE(MODE), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .Sclk(Sclk), .MOSI(MOSI), .SS(SS), .MISO(MISO)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rxq[$];
    logic [7:0] tb_mosi [4];
    logic [7:0] tb_load [4];
    logic [7:0] tb_miso [4];
    bit         tb_doload [4];

    typedef struct {
        logic [1:0] mode;
        bit         load;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [5];

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rxq.push_back(rx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_miso_idle(input string name);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        checks++;
        if (MISO !== 1'bz) begin
            errors++;
            $display("FAIL %s: MISO=%b expected z", name, MISO);
        end
`else
        check(name, 32'(MISO), 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clks(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic do_load(input logic [7:0] v, input logic exp_ready);
        check("tx_ready_pre_load", 32'(tx_ready), 32'(exp_ready));
        tx_data = v;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        check("tx_ready_post_load", 32'(tx_ready), 32'd0);
    endtask

    // Master side of one SS-low frame; abort_bits>0 raises SS after that many Sclk cycles.
    task automatic spi_frame(input logic [1:0] mode, input int nbytes, input int half,
                             input int abort_bits);
        logic       cpol, cpha;
        logic [2:0] bi;
        logic [1:0] kk, kn;
        int         nb;
        cpol = mode[1];
        cpha = mode[0];
        nb   = 0;
        rxq.delete();
        Sclk = cpol;
        MODE = mode;
        wait_clks(4);
        if (tb_doload[0]) do_load(tb_load[0], 1'b1);
        SS = 1'b0;
        wait_clks(half);
        MODE = mode ^ 2'b11;
        for (int k = 0; k < nbytes; k++) begin
            kk = 2'(k);
            kn = 2'(k + 1);
            for (int i = 0; i < 8; i++) begin
                bi = 3'(7 - i);
                if (abort_bits == 0 || nb < abort_bits) begin
                    if (i == 3) begin
                        check("tx_ready_mid_byte", 32'(tx_ready), 32'd1);
                        if (k + 1 < nbytes && tb_doload[kn]) do_load(tb_load[kn], 1'b1);
                    end
                    if (!cpha) begin
                        MOSI = tb_mosi[kk][bi];
                        wait_clks(half);
                        Sclk = ~cpol;
                        tb_miso[kk][bi] = MISO;
                        wait_clks(half);
                        Sclk = cpol;
                    end else begin
                        Sclk = ~cpol;
                        MOSI = tb_mosi[kk][bi];
                        wait_clks(half);
                        tb_miso[kk][bi] = MISO;
                        Sclk = cpol;
                        wait_clks(half);
                    end
                    nb++;
                end
            end
        end
        wait_clks(half);
        SS = 1'b1;
        wait_clks(half);
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 4; k++) begin
            tb_mosi[k]   = 8'h00;
            tb_load[k]   = 8'h00;
            tb_miso[k]   = 8'h00;
            tb_doload[k] = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] rmode;
        int         rbytes;
        int         rhalf;
        logic [7:0] exp_b;

        vecs[0] = '{2'd0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{2'd1, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[2] = '{2'd2, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[3] = '{2'd3, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
        vecs[4] = '{2'd3, 1'b0, 8'hFF, 8'h96, 8'h00, 8'h96};

        // Reset values
        wait_clks(3);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check_miso_idle("reset_miso");
        rst = 1'b1;
        wait_clks(5);

        // Single-byte frames from the vector table
        for (int v = 0; v < 5; v++) begin
            clear_frame();
            tb_doload[0] = vecs[v].load;
            tb_load[0]   = vecs[v].tx;
            tb_mosi[0]   = vecs[v].mosi;
            spi_frame(vecs[v].mode, 1, 8, 0);
            check("vec_miso", 32'(tb_miso[0]), 32'(vecs[v].exp_miso));
            check("vec_rx_count", 32'(rxq.size()), 32'd1);
            if (rxq.size() > 0) check("vec_rx_data", 32'(rxq[0]), 32'(vecs[v].exp_rx));
            check("vec_busy_after", 32'(busy), 32'd0);
            check_miso_idle("vec_miso_idle");
            $display("vector %0d mode=%0d master_rx=%h slave_rx_pulses=%0d", v, vecs[v].mode,
                     tb_miso[0], rxq.size());
        end

        // tx_load while the buffer is full is ignored
        clear_frame();
        do_load(8'h33, 1'b1);
        do_load(8'h44, 1'b0);
        tb_mosi[0] = 8'h5C;
        spi_frame(2'd0, 1, 8, 0);
        check("full_load_ignored_miso", 32'(tb_miso[0]), 32'h33);
        check("full_load_rx_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) check("full_load_rx_data", 32'(rxq[0]), 32'h5C);
        $display("ignored-load frame master_rx=%h", tb_miso[0]);

        // SS raised after 5 Sclk cycles, then a full frame
        clear_frame();
        tb_doload[0] = 1'b1;
        tb_load[0]   = 8'h77;
        tb_mosi[0]   = 8'hAB;
        spi_frame(2'd1, 1, 8, 5);
        check("abort_rx_count", 32'(rxq.size()), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_tx_ready", 32'(tx_ready), 32'd1);
        $display("aborted frame rx_pulses=%0d busy=%0d", rxq.size(), busy);
        clear_frame();
        tb_doload[0] = 1'b1;
        tb_load[0]   = 8'h0F;
        tb_mosi[0]   = 8'hF0;
        spi_frame(2'd1, 1, 8, 0);
        check("post_abort_rx_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) check("post_abort_rx_data", 32'(rxq[0]), 32'hF0);
        check("post_abort_miso", 32'(tb_miso[0]), 32'h0F);
        $display("post-abort frame slave_rx=%h master_rx=%h", rx_data, tb_miso[0]);

        // Randomized frames against the buffer model: each byte is the one loaded for it, else 00
        for (int f = 0; f < 16; f++) begin
            clear_frame();
            rmode  = 2'($urandom_range(0, 3));
            rbytes = $urandom_range(1, 3);
            rhalf  = $urandom_range(8, 12);
            for (int k = 0; k < rbytes; k++) begin
                tb_mosi[k]   = 8'($urandom);
                tb_load[k]   = 8'($urandom);
                tb_doload[k] = ($urandom_range(0, 3) != 0);
            end
            spi_frame(rmode, rbytes, rhalf, 0);
            check("rand_rx_count", 32'(rxq.size()), 32'(rbytes));
            for (int k = 0; k < rbytes; k++) begin
                exp_b = tb_doload[k] ? tb_load[k] : 8'h00;
                check("rand_miso", 32'(tb_miso[k]), 32'(exp_b));
                if (k < rxq.size()) check("rand_rx_data", 32'(rxq[k]), 32'(tb_mosi[k]));
            end
            check("rand_busy_after", 32'(busy), 32'd0);
            $display("random frame %0d mode=%0d bytes=%0d half=%0d rx_pulses=%0d", f, rmode,
                     rbytes, rhalf, rxq.size());
        end

        // Two-byte frame with refill during byte 1
        clear_frame();
        tb_doload[0] = 1'b1;
        tb_load[0]   = 8'h11;
        tb_doload[1] = 1'b1;
        tb_load[1]   = 8'h22;
        tb_mosi[0]   = 8'h01;
        tb_mosi[1]   = 8'h02;
        spi_frame(2'd0, 2, 8, 0);
        check("two_byte_miso0", 32'(tb_miso[0]), 32'h11);
        check("two_byte_miso1", 32'(tb_miso[1]), 32'h22);
        check("two_byte_rx_count", 32'(rxq.size()), 32'd2);
        if (rxq.size() > 1) begin
            check("two_byte_rx0", 32'(rxq[0]), 32'h01);
            check("two_byte_rx1", 32'(rxq[1]), 32'h02);
        end
        $display("two-byte frame master_rx=%h %h", tb_miso[0], tb_miso[1]);

        // Reset pulsed mid-byte
        rxq.delete();
        do_load(8'h99, 1'b1);
        MODE = 2'd0;
        Sclk = 1'b0;
        SS   = 1'b0;
        wait_clks(12);
        for (int i = 0; i < 3; i++) begin
            MOSI = 1'b1;
            wait_clks(8);
            Sclk = 1'b1;
            wait_clks(8);
            Sclk = 1'b0;
        end
        check("midreset_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        tick();
        check("midreset_tx_ready", 32'(tx_ready), 32'd1);
        check("midreset_rx_data", 32'(rx_data), 32'd0);
        check("midreset_rx_valid", 32'(rx_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check_miso_idle("midreset_miso");
        SS   = 1'b1;
        MOSI = 1'b0;
        wait_clks(2);
        rst = 1'b1;
        wait_clks(20);
        check("midreset_no_rx_valid", 32'(rxq.size()), 32'd0);
        check("midreset_busy_after", 32'(busy), 32'd0);
        $display("mid-byte reset busy=%0d rx_data=%h", busy, rx_data);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
